// File: rtl/dmux_8_way.sv
// One-to-eight demultiplexer: in is steered to the output chosen by sel, others forced to zero.
// Latency 1 cycle (registered outputs), no backpressure; every non-reset edge reloads all outputs.
module dmux_8_way #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h
);

    logic [7:0]            en;
    logic [7:0][WIDTH-1:0] out_d;
    logic [7:0][WIDTH-1:0] out_q;

    always_comb begin
        en      = '0;
        en[sel] = 1'b1;
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < 8; i++) begin
            out_d[i] = en[i] ? in : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign a = out_q[0];
    assign b = out_q[1];
    assign c = out_q[2];
    assign d = out_q[3];
    assign e = out_q[4];
    assign f = out_q[5];
    assign g = out_q[6];
    assign h = out_q[7];

endmodule

// File: tb/tb_dmux_8_way.sv
// Scoreboarded bench for dmux_8_way at WIDTH=1 and WIDTH=8 sharing clock, reset and sel.
module tb_dmux_8_way;

    logic       clk;
    logic       reset;
    logic [2:0] sel;
    logic       in1;
    logic [7:0] in8;

    logic a1, b1, c1, d1, e1, f1, g1, h1;
    logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;

    typedef struct {
        logic [7:0]  exp1;
        logic [63:0] exp8;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    dmux_8_way #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .in(in1), .sel(sel),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1)
    );

    dmux_8_way #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in(in8), .sel(sel),
        .a(a8), .b(b8), .c(c8), .d(d8), .e(e8), .f(f8), .g(g8), .h(h8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model1(input logic rst, input logic din, input logic [2:0] s);
        logic [7:0] r;
        r = 8'h00;
        if (!rst && din) r = 8'h01 << s;
        return r;
    endfunction

    function automatic logic [63:0] model8(input logic rst, input logic [7:0] din, input logic [2:0] s);
        logic [63:0] r;
        r = 64'h0;
        if (!rst) r = {56'h0, din} << (8 * s);
        return r;
    endfunction

    function automatic logic [7:0] obs1();
        return {h1, g1, f1, e1, d1, c1, b1, a1};
    endfunction

    function automatic logic [63:0] obs8();
        return {h8, g8, f8, e8, d8, c8, b8, a8};
    endfunction

    // Drive one input set, record the expected result, then compare one edge later.
    task automatic step(input string tag, input logic rst, input logic [2:0] s,
                        input logic din1, input logic [7:0] din8);
        exp_t ex;
        reset = rst;
        sel   = s;
        in1   = din1;
        in8   = din8;
        ex.exp1 = model1(rst, din1, s);
        ex.exp8 = model8(rst, din8, s);
        ex.tag  = tag;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, 64'd1, 64'd0);
        end else begin
            ex = exp_q.pop_front();
            chk({ex.tag, "_w1"}, {56'h0, obs1()}, {56'h0, ex.exp1});
            chk({ex.tag, "_w8"}, obs8(), ex.exp8);
        end
    endtask

    initial begin
        reset = 1'b1;
        sel   = 3'd5;
        in1   = 1'b1;
        in8   = 8'hFF;
        @(negedge clk);

        // Reset held two edges with nonzero inputs, then release.
        step("rst0", 1'b1, 3'd5, 1'b1, 8'hFF);
        step("rst1", 1'b1, 3'd5, 1'b1, 8'hFF);
        step("rel_f", 1'b0, 3'd5, 1'b1, 8'h3C);

        for (int i = 0; i < 8; i++) begin
            step($sformatf("in0_s%0d", i), 1'b0, 3'(i), 1'b0, 8'h00);
        end
        for (int i = 0; i < 8; i++) begin
            step($sformatf("in1_s%0d", i), 1'b0, 3'(i), 1'b1, 8'(8'h11 * (i + 1)));
        end

        // sel changed between edges must not reach the outputs before the next edge.
        step("iso_c", 1'b0, 3'd2, 1'b1, 8'h5A);
        sel = 3'd6;
        #2;
        chk("iso_hold_w1", {56'h0, obs1()}, {56'h0, 8'h04});
        chk("iso_hold_w8", obs8(), model8(1'b0, 8'h5A, 3'd2));
        step("iso_g", 1'b0, 3'd6, 1'b1, 8'h5A);

        step("mid_d", 1'b0, 3'd3, 1'b1, 8'h77);
        step("mid_rst", 1'b1, 3'd3, 1'b1, 8'h77);
        step("mid_rel", 1'b0, 3'd3, 1'b1, 8'h77);

        step("w8_h", 1'b0, 3'd7, 1'b1, 8'hA5);
        step("w8_a", 1'b0, 3'd0, 1'b1, 8'hA5);
        step("swap", 1'b0, 3'd4, 1'b0, 8'h81);
        step("both", 1'b0, 3'd1, 1'b1, 8'h00);

        for (int i = 0; i < 12; i++) begin
            logic [2:0] rs;
            logic [7:0] rd;
            rs = 3'($urandom_range(0, 7));
            rd = 8'($urandom);
            step($sformatf("rnd%0d", i), 1'b0, rs, rd[0], rd);
        end

        if (exp_q.size() != 0) chk("q_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
